// File: rtl/keylock_pkg.sv
// Shared types and constants for the keypad lock sequencer and its digit buffer.
package keylock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_ENTER     = 4'd9;
  localparam logic [3:0] KEY_DIGIT_MIN = 4'd1;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd8;

  localparam logic [1:0] PAT_OK      = 2'd0;
  localparam logic [1:0] PAT_ERR     = 2'd1;
  localparam logic [1:0] PAT_LOCKOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_OPEN    = 3'd1,
    ST_PROG    = 3'd2,
    ST_BLINK   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Only keys 1..8 are code digits; everything else except ENTER is ignored.
  function automatic logic is_digit(input logic [3:0] k);
    return (k >= KEY_DIGIT_MIN) && (k <= KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/keylock_sequencer_if.sv
// Key-event input and pattern-engine handshake of the lock sequencer.
// master = the sequencer, slave = keypad scanner / pattern engine side.
interface keylock_sequencer_if;
  logic [3:0] key;
  logic       key_valid;
  logic       pat_req;
  logic [1:0] pat_sel;
  logic       pat_done;

  modport master (
    input  key, key_valid, pat_done,
    output pat_req, pat_sel
  );

  modport slave (
    output key, key_valid, pat_done,
    input  pat_req, pat_sel
  );
endinterface

// File: rtl/keylock_digit_buf.sv
// Entered-digit buffer: shifts digits in from the right, counts them, and
// flags an overflow once a further digit arrives on a full buffer.
module keylock_digit_buf
  import keylock_pkg::*;
#(
  parameter int CODE_LEN = 6,
  parameter int CNT_W    = $clog2(CODE_LEN + 1)
) (
  input  logic                        hwclk,
  input  logic                        reset_n,
  input  logic [DIGIT_W-1:0]          digit,
  input  logic                        shift,
  input  logic                        clear,
  output logic [CODE_LEN*DIGIT_W-1:0] buf_data,
  output logic [CNT_W-1:0]            count,
  output logic                        ovf
);

  localparam int BUF_W = CODE_LEN * DIGIT_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // Clear wins over shift; a digit on a full buffer only raises the overflow flag.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (shift) begin
      if (r_cnt == CNT_FULL) begin
        r_ovf <= 1'b1;
      end else begin
        r_buf <= {r_buf[BUF_W-DIGIT_W-1:0], digit};
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign buf_data = r_buf;
  assign count    = r_cnt;
  assign ovf      = r_ovf;

endmodule

// File: rtl/keylock_sequencer.sv
// Central keypad-lock FSM: checks entered codes against the user code or the
// programming code, drives the blink-pattern handshake and the lock LEDs, and
// owns the user code, the failure counter and the lockout/relock timer.
module keylock_sequencer
  import keylock_pkg::*;
#(
  parameter int unsigned                 CODE_LEN    = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_UC  = 24'h666666,
  parameter logic [CODE_LEN*DIGIT_W-1:0] PC          = 24'h555116,
  parameter int unsigned                 MAX_FAILS   = 3,
  parameter int unsigned                 LOCKOUT_CYC = 120000000,
  parameter int unsigned                 RELOCK_CYC  = 360000000
) (
  input  logic                        hwclk,
  input  logic                        reset_n,
  keylock_sequencer_if.master         bus,
  output logic                        led_locked,
  output logic                        led_open,
  output logic                        led_prog,
  output logic [CODE_LEN*DIGIT_W-1:0] user_code,
  output logic [1:0]                  fail_count
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TMR_W  = 32;

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [1:0]       FAIL_MAX     = 2'(MAX_FAILS);
  localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] RELOCK_LAST  = TMR_W'(RELOCK_CYC - 1);

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_nxt;
  logic               r_pat_req, w_pat_req_nxt;
  logic [1:0]         r_pat_sel, w_pat_sel_nxt;
  logic [1:0]         r_fail, w_fail_nxt;
  logic [CODE_W-1:0]  r_uc, w_uc_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_led_locked, r_led_open, r_led_prog;
  logic               w_led_locked_nxt, w_led_open_nxt, w_led_prog_nxt;

  logic [CODE_W-1:0]  w_buf;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_ovf;
  logic               w_key_state, w_relock, w_lock_done;
  logic               w_key_acc, w_enter_acc, w_shift, w_clear, w_full;
  logic [1:0]         w_fail_inc;

  // A timer expiry takes priority over a coincident key, so the key is dropped.
  assign w_key_state = (r_state == ST_LOCKED) || (r_state == ST_OPEN) || (r_state == ST_PROG);
  assign w_relock    = (r_state == ST_OPEN) && (r_timer == RELOCK_LAST);
  assign w_lock_done = (r_state == ST_LOCKOUT) && (r_timer == LOCKOUT_LAST);
  assign w_key_acc   = bus.key_valid && w_key_state && !w_relock;
  assign w_enter_acc = w_key_acc && (bus.key == KEY_ENTER);
  assign w_shift     = w_key_acc && is_digit(bus.key);
  assign w_clear     = w_enter_acc || (w_state_nxt != r_state);
  assign w_full      = (w_cnt == CNT_FULL);
  assign w_fail_inc  = r_fail + 2'd1;

  keylock_digit_buf #(
    .CODE_LEN (CODE_LEN)
  ) u_buf (
    .hwclk    (hwclk),
    .reset_n  (reset_n),
    .digit    (bus.key),
    .shift    (w_shift),
    .clear    (w_clear),
    .buf_data (w_buf),
    .count    (w_cnt),
    .ovf      (w_ovf)
  );

  // Next-state, pattern request, failure count and user-code decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_pat_req_nxt = r_pat_req;
    w_pat_sel_nxt = r_pat_sel;
    w_fail_nxt    = r_fail;
    w_uc_nxt      = r_uc;
    case (r_state)
      ST_LOCKED: begin
        if (w_enter_acc) begin
          w_state_nxt = ST_BLINK;
          if (w_full && !w_ovf && (w_buf == r_uc)) begin
            w_fail_nxt    = 2'd0;
            w_pat_sel_nxt = PAT_OK;
            w_ret_nxt     = ST_OPEN;
          end else if (w_full) begin
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_MAX) begin
              w_pat_sel_nxt = PAT_LOCKOUT;
              w_ret_nxt     = ST_LOCKOUT;
            end else begin
              w_pat_sel_nxt = PAT_ERR;
              w_ret_nxt     = ST_LOCKED;
            end
          end else begin
            w_pat_sel_nxt = PAT_ERR;
            w_ret_nxt     = ST_LOCKED;
          end
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (w_relock) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_enter_acc) begin
          if (w_cnt == CNT_ZERO) begin
            w_state_nxt = ST_LOCKED;
          end else if (w_full && (w_buf == PC)) begin
            w_state_nxt = ST_PROG;
          end else begin
            w_state_nxt   = ST_BLINK;
            w_pat_sel_nxt = PAT_ERR;
            w_ret_nxt     = ST_OPEN;
          end
        end else begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_PROG: begin
        if (w_enter_acc) begin
          w_state_nxt = ST_BLINK;
          if (w_full && !w_ovf) begin
            w_uc_nxt      = w_buf;
            w_pat_sel_nxt = PAT_OK;
            w_ret_nxt     = ST_OPEN;
          end else begin
            w_pat_sel_nxt = PAT_ERR;
            w_ret_nxt     = ST_PROG;
          end
        end else begin
          w_state_nxt = ST_PROG;
        end
      end
      ST_BLINK: begin
        if (bus.pat_done) begin
          w_pat_req_nxt = 1'b0;
          w_state_nxt   = r_ret;
        end else begin
          w_pat_req_nxt = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (w_lock_done) begin
          w_fail_nxt  = 2'd0;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt   = ST_LOCKED;
        w_pat_req_nxt = 1'b0;
      end
    endcase
  end

  // Shared timer: idle count in OPEN (restarted by keys), duration count in LOCKOUT.
  always_comb begin
    w_timer_nxt = '0;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if ((r_state == ST_OPEN) && w_key_acc) begin
      w_timer_nxt = '0;
    end else if ((r_state == ST_OPEN) || (r_state == ST_LOCKOUT)) begin
      w_timer_nxt = r_timer + 32'd1;
    end else begin
      w_timer_nxt = '0;
    end
  end

  // LED decode from the upcoming state so the registered LEDs track the state register.
  always_comb begin
    w_led_locked_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_LOCKOUT);
    w_led_open_nxt   = (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PROG);
    w_led_prog_nxt   = (w_state_nxt == ST_PROG);
  end

  // State and output registers; reset drops pat_req immediately.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_LOCKED;
      r_ret        <= ST_LOCKED;
      r_pat_req    <= 1'b0;
      r_pat_sel    <= PAT_OK;
      r_fail       <= 2'd0;
      r_uc         <= DEFAULT_UC;
      r_timer      <= '0;
      r_led_locked <= 1'b1;
      r_led_open   <= 1'b0;
      r_led_prog   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_pat_req    <= w_pat_req_nxt;
      r_pat_sel    <= w_pat_sel_nxt;
      r_fail       <= w_fail_nxt;
      r_uc         <= w_uc_nxt;
      r_timer      <= w_timer_nxt;
      r_led_locked <= w_led_locked_nxt;
      r_led_open   <= w_led_open_nxt;
      r_led_prog   <= w_led_prog_nxt;
    end
  end

  assign bus.pat_req = r_pat_req;
  assign bus.pat_sel = r_pat_sel;
  assign led_locked  = r_led_locked;
  assign led_open    = r_led_open;
  assign led_prog    = r_led_prog;
  assign user_code   = r_uc;
  assign fail_count  = r_fail;

endmodule
